uart_cmd_responder: RTL and testbench

//  Device-side end of the host UART command link. Consumes bytes from the UART

---
 rtl/uart_cmd_pkg.sv | 17 +
 rtl/uart_cmd_regfile.sv | 34 +++
 rtl/uart_cmd_responder.sv | 146 ++++++++++++++
 tb/tb_uart_cmd_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command responder and its bench.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_WR  = 8'hA1;
    localparam logic [7:0] CMD_RD  = 8'hA2;
    localparam logic [7:0] RSP_NAK = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_ADDR  = 3'd1,
        ST_GET_DATA  = 3'd2,
        ST_EXEC      = 3'd3,
        ST_SEND      = 3'd4,
        ST_WAIT_DONE = 3'd5
    } state_e;

endpackage

// File: rtl/uart_cmd_regfile.sv
// Small register bank: one synchronous write port, flattened combinational read bus.
module uart_cmd_regfile
    import uart_cmd_pkg::*;
#(
    parameter int NREGS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [7:0]         addr,
    input  logic [7:0]         wdata,
    output logic [NREGS*8-1:0] regs
);

    logic [7:0] mem [NREGS];

    // Register storage; the caller only raises we for an in-range address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= 8'h00;
        end else if (we) begin
            for (int i = 0; i < NREGS; i++) begin
                if (addr == 8'(i)) mem[i] <= wdata;
            end
        end
    end

    // Flatten the array so register k sits at regs[8k+7:8k].
    always_comb begin
        regs = '0;
        for (int i = 0; i < NREGS; i++) regs[8*i +: 8] = mem[i];
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// Device-side UART command responder: assembles {cmd, addr, data} frames,
// executes register reads/writes and returns one response byte per frame.
//
//  state        | meaning
//  -------------+----------------------------------------------------------
//  ST_IDLE      | waiting for command byte
//  ST_GET_ADDR  | waiting for address byte (timeout armed)
//  ST_GET_DATA  | waiting for data byte (timeout armed)
//  ST_EXEC      | one cycle: perform write, compute response
//  ST_SEND      | one cycle: tx_wr strobe with response byte
//  ST_WAIT_DONE | holding tx_data until transmitter reports tx_done
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int NREGS       = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_done,
    output logic [7:0]         tx_data,
    output logic               tx_wr,
    input  logic               tx_done,
    output logic [NREGS*8-1:0] regs_o,
    output logic [7:0]         debug_o,
    output logic               busy_o,
    output logic               frame_err_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_e           state;
    logic [7:0]       cmd;
    logic [7:0]       addr;
    logic [7:0]       data_b;
    logic [7:0]       rsp;
    logic [7:0]       rd_byte;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_inc;
    logic             addr_ok;
    logic             we;
    logic             frame_err;
    logic             rx_dropped;

    // Full 8-bit compare so out-of-range addresses never alias onto real registers.
    assign addr_ok    = {1'b0, addr} < 9'(NREGS);
    assign we         = (state == ST_EXEC) && (cmd == CMD_WR) && addr_ok;
    assign tmo_inc    = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;
    assign rx_dropped = rx_done && ((state == ST_EXEC) || (state == ST_SEND) ||
                                    (state == ST_WAIT_DONE));

    assign tx_wr       = (state == ST_SEND);
    assign tx_data     = rsp;
    assign busy_o      = (state != ST_IDLE);
    assign debug_o     = regs_o[7:0];
    assign frame_err_o = frame_err;

    uart_cmd_regfile #(.NREGS(NREGS)) u_regfile (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .we    (we),
        .addr  (addr),
        .wdata (data_b),
        .regs  (regs_o)
    );

    // Read mux over the flattened bus; only meaningful when addr_ok.
    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < NREGS; i++) begin
            if (addr == 8'(i)) rd_byte = regs_o[8*i +: 8];
        end
    end

    // Frame sequencing, timeout and response generation.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            cmd       <= 8'h00;
            addr      <= 8'h00;
            data_b    <= 8'h00;
            rsp       <= 8'h00;
            tmo_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= rx_dropped;
            case (state)
                ST_IDLE: begin
                    if (rx_done) begin
                        cmd <= rx_data;
                        if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                            tmo_cnt <= '0;
                            state   <= ST_GET_ADDR;
                        end else begin
                            rsp   <= RSP_NAK;
                            state <= ST_SEND;
                        end
                    end
                end
                ST_GET_ADDR: begin
                    // A byte arriving in the expiry cycle still wins.
                    if (rx_done) begin
                        addr    <= rx_data;
                        tmo_cnt <= '0;
                        state   <= ST_GET_DATA;
                    end else if (tmo_cnt == TMO_LAST) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_inc;
                    end
                end
                ST_GET_DATA: begin
                    if (rx_done) begin
                        data_b  <= rx_data;
                        tmo_cnt <= '0;
                        state   <= ST_EXEC;
                    end else if (tmo_cnt == TMO_LAST) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_inc;
                    end
                end
                ST_EXEC: begin
                    if (!addr_ok)             rsp <= RSP_NAK;
                    else if (cmd == CMD_WR)   rsp <= ~data_b;
                    else                      rsp <= rd_byte;
                    state <= ST_SEND;
                end
                ST_SEND: begin
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (tx_done) state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder with a response scoreboard.
module tb_uart_cmd_responder;
    import uart_cmd_pkg::*;

    localparam int NREGS = 4;
    localparam int TMO   = 50;

    logic               clk;
    logic               rst;
    logic [7:0]         rx_data;
    logic               rx_done;
    logic [7:0]         tx_data;
    logic               tx_wr;
    logic               tx_done;
    logic [NREGS*8-1:0] regs;
    logic [7:0]         debug;
    logic               busy;
    logic               frame_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    uart_cmd_responder #(.NREGS(NREGS), .TIMEOUT_CYC(TMO)) dut (
        .sys_clk     (clk),
        .sys_rst     (rst),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .tx_data     (tx_data),
        .tx_wr       (tx_wr),
        .tx_done     (tx_done),
        .regs_o      (regs),
        .debug_o     (debug),
        .busy_o      (busy),
        .frame_err_o (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; rx_done is sampled by exactly one rising edge.
    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        chk("wait_idle", {31'd0, ok}, 32'd1);
    endtask

    task automatic frame(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] rsp);
        exp_q.push_back(rsp);
        send(b0);
        send(b1);
        send(b2);
        chk("exec_no_tx", {31'd0, tx_wr}, 32'd0);
        @(negedge clk);
        chk("tx_latency", {31'd0, tx_wr}, 32'd1);
    endtask

    // Transmitter model: finishes each byte a few cycles after tx_wr.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_wr) begin
                repeat (5) @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    // Monitor: every tx_wr strobe pops and checks one expected response.
    initial begin
        logic prev = 1'b0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst && tx_wr) begin
                checks++;
                if (prev) begin
                    errors++;
                    $display("FAIL tx_wr_back_to_back: got 2 consecutive strobes required 1");
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tx: got %h required no response", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL response: got %h expected %h", tx_data, e);
                    end
                end
            end
            prev = rst ? 1'b0 : tx_wr;
        end
    end

    initial begin
        logic [NREGS*8-1:0] saved;
        int n;
        bit seen;
        rst = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
        chk("rst_tx_wr", {31'd0, tx_wr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_regs", regs, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Write reg0, response is inverted data.
        frame(CMD_WR, 8'h00, 8'h01, 8'hFE);
        chk("debug_reg0", {24'd0, debug}, 32'h01);
        wait_idle();

        // Write then read back reg3.
        frame(CMD_WR, 8'h03, 8'h5A, 8'hA5);
        chk("reg3_write", {24'd0, regs[31:24]}, 32'h5A);
        wait_idle();
        frame(CMD_RD, 8'h03, 8'h00, 8'h5A);
        wait_idle();

        // Out-of-range addresses NAK and leave the bank alone.
        saved = regs;
        frame(CMD_WR, 8'h07, 8'h11, RSP_NAK);
        wait_idle();
        frame(CMD_WR, 8'h04, 8'h22, RSP_NAK);
        wait_idle();
        frame(CMD_WR, 8'h84, 8'h99, RSP_NAK);
        wait_idle();
        frame(CMD_RD, 8'h04, 8'h00, RSP_NAK);
        wait_idle();
        chk("regs_unchanged", regs, saved);

        // Unknown command: NAK one cycle after the byte.
        exp_q.push_back(RSP_NAK);
        send(8'h3C);
        chk("unknown_tx_latency", {31'd0, tx_wr}, 32'd1);
        wait_idle();
        chk("unknown_back_idle", {31'd0, busy}, 32'd0);

        // Timeout mid-frame: error pulse after TMO idle cycles, no response.
        send(CMD_WR);
        send(8'h01);
        n = 0;
        seen = 0;
        for (int i = 1; i <= TMO + 10 && !seen; i++) begin
            @(negedge clk);
            if (frame_err) begin
                seen = 1;
                n = i;
            end
        end
        chk("timeout_cycles", n, TMO);
        @(negedge clk);
        chk("frame_err_pulse", {31'd0, frame_err}, 32'd0);
        chk("timeout_idle", {31'd0, busy}, 32'd0);
        frame(CMD_WR, 8'h01, 8'h22, 8'hDD);
        chk("reg1_write", {24'd0, regs[15:8]}, 32'h22);
        wait_idle();

        // Byte arriving in the expiry cycle is accepted.
        exp_q.push_back(8'hCC);
        send(CMD_WR);
        send(8'h02);
        repeat (TMO - 1) @(negedge clk);
        send(8'h33);
        chk("expiry_byte_wins", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("expiry_tx", {31'd0, tx_wr}, 32'd1);
        chk("reg2_write", {24'd0, regs[23:16]}, 32'h33);
        wait_idle();

        // Byte during WAIT_DONE is dropped with an error pulse; state kept.
        frame(CMD_RD, 8'h00, 8'h00, 8'h01);
        @(negedge clk);
        send(8'h55);
        chk("drop_frame_err", {31'd0, frame_err}, 32'd1);
        chk("drop_busy", {31'd0, busy}, 32'd1);
        wait_idle();

        // Reset while waiting for tx_done.
        frame(CMD_WR, 8'h02, 8'h77, 8'h88);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_wr", {31'd0, tx_wr}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_regs", regs, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        frame(CMD_RD, 8'h00, 8'h00, 8'h00);
        wait_idle();

        repeat (5) @(negedge clk);
        chk("all_responses_seen", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
